// File: rtl/cas_feeder.sv
// cas_feeder: streams a loaded cassette image from download memory into the
// cassette square-wave generator, one byte per generator cycle. Each byte is
// fetched, handed to the generator with a one-clock start pulse, and the
// feeder then waits for the generator's (synchronised) done before moving on.
// Gated by the cassette motor line; raises eot once the whole image has been sent.
//
// Optional build macro CAS_LEADER_EN: when defined, every motor-on from PAUSE
// first emits LEADER_LEN bytes of 0x55 before resuming memory bytes.
module cas_feeder #(
    parameter int AW = 16
`ifdef CAS_LEADER_EN
    , parameter int LEADER_LEN = 128
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tape_loaded,
    input  logic [AW-1:0] tape_size,
    input  logic          motor,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic          mem_ack,
    input  logic [7:0]    mem_din,
    output logic          gen_start,
    output logic [7:0]    gen_din,
    input  logic          gen_done,
    output logic          busy,
    output logic          eot
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PAUSE     = 3'd1;
    localparam logic [2:0] ST_FETCH     = 3'd2;
    localparam logic [2:0] ST_START     = 3'd3;
    localparam logic [2:0] ST_WAIT_CLR  = 3'd4;
    localparam logic [2:0] ST_WAIT_DONE = 3'd5;
    localparam logic [2:0] ST_END       = 3'd6;

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [AW-1:0] addr_nx;
    logic [AW-1:0] addr_inc;
    logic [7:0]    din_nx;
    logic          loaded_q;
    logic          done_meta;
    logic          done_s;

`ifdef CAS_LEADER_EN
    localparam int LW = (LEADER_LEN > 1) ? $clog2(LEADER_LEN) : 1;
    logic [LW-1:0] ldr_cnt;
    logic [LW-1:0] ldr_cnt_nx;
    logic          in_ldr;
    logic          in_ldr_nx;
`endif

    // Tape position after the byte currently in flight completes.
    assign addr_inc = mem_addr + {{(AW-1){1'b0}}, 1'b1};

    // Bring the generator's done into the clk domain through two flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_meta <= 1'b0;
            done_s    <= 1'b0;
        end else begin
            done_meta <= gen_done;
            done_s    <= done_meta;
        end
    end

    // Next-state, next-address and next-byte decisions.
    always_comb begin
        state_nx = state;
        addr_nx  = mem_addr;
        din_nx   = gen_din;
`ifdef CAS_LEADER_EN
        ldr_cnt_nx = ldr_cnt;
        in_ldr_nx  = in_ldr;
`endif
        if (!tape_loaded) begin
            // Unload aborts everything, including a read acked this same cycle.
            state_nx = ST_IDLE;
`ifdef CAS_LEADER_EN
            in_ldr_nx = 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_PAUSE;
                    if (!loaded_q) begin
                        addr_nx = {AW{1'b0}};
                    end else begin
                        addr_nx = mem_addr;
                    end
                end
                ST_PAUSE: begin
                    if (tape_size == {AW{1'b0}}) begin
                        state_nx = ST_END;
                    end else if (motor) begin
`ifdef CAS_LEADER_EN
                        state_nx   = ST_START;
                        din_nx     = 8'h55;
                        ldr_cnt_nx = LW'(LEADER_LEN - 1);
                        in_ldr_nx  = 1'b1;
`else
                        state_nx = ST_FETCH;
`endif
                    end else begin
                        state_nx = ST_PAUSE;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        din_nx   = mem_din;
                        state_nx = ST_START;
                    end else begin
                        state_nx = ST_FETCH;
                    end
                end
                ST_START: begin
                    state_nx = ST_WAIT_CLR;
                end
                ST_WAIT_CLR: begin
                    // A done still high from the previous byte must drop first.
                    if (!done_s) begin
                        state_nx = ST_WAIT_DONE;
                    end else begin
                        state_nx = ST_WAIT_CLR;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_s) begin
`ifdef CAS_LEADER_EN
                        if (in_ldr) begin
                            if (ldr_cnt == {LW{1'b0}}) begin
                                in_ldr_nx = 1'b0;
                                state_nx  = motor ? ST_FETCH : ST_PAUSE;
                            end else if (motor) begin
                                ldr_cnt_nx = ldr_cnt - LW'(1);
                                din_nx     = 8'h55;
                                state_nx   = ST_START;
                            end else begin
                                // Motor dropped mid-leader: next motor-on restarts it.
                                in_ldr_nx = 1'b0;
                                state_nx  = ST_PAUSE;
                            end
                        end else begin
                            addr_nx = addr_inc;
                            if (addr_inc == tape_size) begin
                                state_nx = ST_END;
                            end else if (motor) begin
                                state_nx = ST_FETCH;
                            end else begin
                                state_nx = ST_PAUSE;
                            end
                        end
`else
                        addr_nx = addr_inc;
                        if (addr_inc == tape_size) begin
                            state_nx = ST_END;
                        end else if (motor) begin
                            state_nx = ST_FETCH;
                        end else begin
                            state_nx = ST_PAUSE;
                        end
`endif
                    end else begin
                        state_nx = ST_WAIT_DONE;
                    end
                end
                ST_END: begin
                    state_nx = ST_END;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            loaded_q  <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_rd    <= 1'b0;
            gen_start <= 1'b0;
            gen_din   <= 8'h00;
            busy      <= 1'b0;
            eot       <= 1'b0;
        end else begin
            state     <= state_nx;
            loaded_q  <= tape_loaded;
            mem_addr  <= addr_nx;
            mem_rd    <= (state_nx == ST_FETCH);
            gen_start <= (state_nx == ST_START);
            gen_din   <= din_nx;
            busy      <= (state_nx != ST_IDLE) && (state_nx != ST_PAUSE) && (state_nx != ST_END);
            eot       <= (state_nx == ST_END);
        end
    end

`ifdef CAS_LEADER_EN
    // Leader byte counter and leader-in-progress flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ldr_cnt <= {LW{1'b0}};
            in_ldr  <= 1'b0;
        end else begin
            ldr_cnt <= ldr_cnt_nx;
            in_ldr  <= in_ldr_nx;
        end
    end
`endif

endmodule

// File: tb/tb_cas_feeder.sv
// Self-checking bench for cas_feeder: memory and generator models, a queue of
// expected generator bytes, and directed load / motor / abort scenarios.
module tb_cas_feeder;

    localparam int AW = 16;
`ifdef CAS_LEADER_EN
    localparam int LDR = 4;
`else
    localparam int LDR = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tape_loaded = 1'b0;
    logic [AW-1:0] tape_size = '0;
    logic          motor = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_ack = 1'b0;
    logic [7:0]    mem_din = 8'h00;
    logic          gen_start;
    logic [7:0]    gen_din;
    logic          gen_done = 1'b0;
    logic          busy;
    logic          eot;

    cas_feeder #(
        .AW(AW)
`ifdef CAS_LEADER_EN
        , .LEADER_LEN(4)
`endif
    ) dut (
        .clk(clk), .reset(reset), .tape_loaded(tape_loaded), .tape_size(tape_size),
        .motor(motor), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack),
        .mem_din(mem_din), .gen_start(gen_start), .gen_din(gen_din),
        .gen_done(gen_done), .busy(busy), .eot(eot)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:15];
    logic [7:0] exp_q[$];
    int rd_log[$];
    int checks = 0;
    int errors = 0;
    int ack_dly = 1;
    int done_dly = 20;
    int done_hold = 3;
    int rd_cnt = 0;
    int rd_run = 0;
    int last_rd_run = 0;
    int start_cnt = 0;
    int cyc = 0;
    int last_start_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_leader();
        for (int i = 0; i < LDR; i++) exp_q.push_back(8'h55);
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) exp_q.push_back(mem[i]);
    endtask

    task automatic wait_eot(input string tag);
        int n;
        n = 0;
        while (eot !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, eot}, 32'd1);
    endtask

    task automatic wait_starts(input int target, input string tag);
        int n;
        n = 0;
        while (start_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, start_cnt, target);
    endtask

    task automatic unload();
        tape_loaded = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Memory model: acks a held read after ack_dly cycles.
    initial begin
        int wn;
        wn = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_rd === 1'b1) begin
                wn++;
                if (wn >= ack_dly) begin
                    mem_ack = 1'b1;
                    mem_din = mem[mem_addr[3:0]];
                    wn = 0;
                end
            end else begin
                wn = 0;
            end
        end
    end

    // Generator model: done rises done_dly cycles after start, held done_hold cycles.
    initial begin
        int dly_cnt;
        int hold_cnt;
        dly_cnt = 0;
        hold_cnt = 0;
        forever begin
            @(negedge clk);
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) gen_done = 1'b0;
            end
            if (dly_cnt > 0) begin
                dly_cnt--;
                if (dly_cnt == 0) begin
                    gen_done = 1'b1;
                    hold_cnt = done_hold;
                end
            end
            if (gen_start === 1'b1) dly_cnt = done_dly;
        end
    end

    // Monitor: counts reads and starts, scoreboards gen_din on each start.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_rd === 1'b1) begin
                if (rd_run == 0) begin
                    rd_cnt++;
                    rd_log.push_back(int'(mem_addr));
                end
                rd_run++;
            end else begin
                if (rd_run > 0) last_rd_run = rd_run;
                rd_run = 0;
            end
            if (gen_start === 1'b1) begin
                start_cnt++;
                last_start_cyc = cyc;
                if (exp_q.size() == 0) chk("start_unexpected", {24'd0, gen_din}, 32'hFFFF_FFFF);
                else chk("gen_din", {24'd0, gen_din}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int b0;
        int r0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_start", {31'd0, gen_start}, 32'd0);
        chk("rst_din", {24'd0, gen_din}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_eot", {31'd0, eot}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: three-byte tape streamed with motor on
        mem[0] = 8'h3C; mem[1] = 8'hA5; mem[2] = 8'h00;
        tape_size = 16'd3;
        motor = 1'b1;
        push_leader(); push_range(0, 3);
        tape_loaded = 1'b1;
        wait_eot("t1_eot");
        chk("t1_addr", {16'd0, mem_addr}, 32'd3);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_starts", start_cnt, 3 + LDR);
        chk("t1_rds", rd_cnt, 3);
        chk("t1_queue", exp_q.size(), 0);

        // 2: empty tape goes straight to END
        unload();
        chk("t2_eot_clr", {31'd0, eot}, 32'd0);
        b0 = start_cnt; r0 = rd_cnt;
        tape_size = 16'd0;
        tape_loaded = 1'b1;
        repeat (2) @(negedge clk);
        chk("t2_eot", {31'd0, eot}, 32'd1);
        chk("t2_addr", {16'd0, mem_addr}, 32'd0);
        chk("t2_rds", rd_cnt - r0, 0);
        chk("t2_starts", start_cnt - b0, 0);

        // 3: motor drop after 2nd byte, resume from address 2
        unload();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        tape_size = 16'd4;
        motor = 1'b1;
        push_leader(); push_range(0, 2);
        b0 = start_cnt; r0 = rd_cnt;
        tape_loaded = 1'b1;
        wait_starts(b0 + LDR + 2, "t3_second_start");
        repeat (5) @(negedge clk);
        motor = 1'b0;
        repeat (40) @(negedge clk);
        chk("t3_pause_addr", {16'd0, mem_addr}, 32'd2);
        chk("t3_pause_rds", rd_cnt - r0, 2);
        chk("t3_pause_busy", {31'd0, busy}, 32'd0);
        chk("t3_pause_eot", {31'd0, eot}, 32'd0);
        push_leader(); push_range(2, 4);
        motor = 1'b1;
        wait_eot("t3_eot");
        chk("t3_resume_addr", (rd_log.size() > r0 + 2) ? rd_log[r0 + 2] : -1, 2);
        chk("t3_addr", {16'd0, mem_addr}, 32'd4);
        chk("t3_rds", rd_cnt - r0, 4);
        chk("t3_queue", exp_q.size(), 0);

        // 4: slow ack, and a long done that is still high at the next start
        unload();
        ack_dly = 7; done_hold = 15;
        mem[0] = 8'h5A; mem[1] = 8'hC3;
        tape_size = 16'd2;
        push_leader(); push_range(0, 2);
        r0 = rd_cnt;
        tape_loaded = 1'b1;
        wait_eot("t4_eot");
        chk("t4_rd_held", last_rd_run, 7);
        chk("t4_rds", rd_cnt - r0, 2);
        chk("t4_stale_done", {31'd0, (cyc - last_start_cyc) >= 18}, 32'd1);
        chk("t4_queue", exp_q.size(), 0);
        ack_dly = 1; done_hold = 3;
        repeat (20) @(negedge clk);

        // 5: unload during WAIT_DONE, then reload restarts from byte 0
        unload();
        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;
        tape_size = 16'd3;
        push_leader(); push_range(0, 2);
        b0 = start_cnt;
        tape_loaded = 1'b1;
        wait_starts(b0 + LDR + 2, "t5_second_start");
        repeat (10) @(negedge clk);
        tape_loaded = 1'b0;
        @(negedge clk);
        chk("t5_abort_busy", {31'd0, busy}, 32'd0);
        chk("t5_abort_rd", {31'd0, mem_rd}, 32'd0);
        chk("t5_abort_addr", {16'd0, mem_addr}, 32'd1);
        repeat (30) @(negedge clk);
        chk("t5_abort_queue", exp_q.size(), 0);
        push_leader(); push_range(0, 3);
        r0 = rd_cnt;
        tape_loaded = 1'b1;
        @(negedge clk);
        chk("t5_reload_addr", {16'd0, mem_addr}, 32'd0);
        chk("t5_reload_eot", {31'd0, eot}, 32'd0);
        wait_eot("t5_eot");
        chk("t5_first_rd", (rd_log.size() > r0) ? rd_log[r0] : -1, 0);
        chk("t5_addr", {16'd0, mem_addr}, 32'd3);
        chk("t5_queue", exp_q.size(), 0);

`ifdef CAS_LEADER_EN
        // 6: leader bytes precede a one-byte tape
        unload();
        mem[0] = 8'h11;
        tape_size = 16'd1;
        push_leader(); push_range(0, 1);
        r0 = rd_cnt;
        tape_loaded = 1'b1;
        wait_eot("t6_eot");
        chk("t6_rds", rd_cnt - r0, 1);
        chk("t6_addr", {16'd0, mem_addr}, 32'd1);
        chk("t6_queue", exp_q.size(), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
